fft_buf_in: RTL and testbench
=============================

# fft_buf_in

Input reorder buffer for the 64-point FFT datapath. Accepts one complex sample per cycle in natural order, stores a full 64-sample frame, then issues it as eight 8-sample groups with stride 8, packed in the format the 8-point butterfly core expects. It sits directly upstream of the first radix-8 butterfly stage. Optional ping-pong banking lets frame N+1 stream in while frame N is read out.

## Interface
- `DATA_WD`, default 16: width of each real or imaginary sample, two's complement.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rstn`, input, 1: reset; asynchronous, active-low.
- `dat_val_i`, input, 1: an input sample is valid.
- `dat_rdy_o`, output, 1: the buffer can accept a sample this cycle.
- `dat_re_i`, input, DATA_WD: real part of the input sample.
- `dat_im_i`, input, DATA_WD: imaginary part of the input sample.
- `grp_val_o`, output, 1: an output group is valid.
- `grp_rdy_i`, input, 1: downstream accepts the group.
- `grp_re_o`, output, 8*DATA_WD: real parts of the 8 group samples; slot 0 in [8*DATA_WD-1 : 7*DATA_WD], slot 7 in [DATA_WD-1 : 0].
- `grp_im_o`, output, 8*DATA_WD: imaginary parts, same packing as `grp_re_o`.
- `grp_idx_o`, output, 3: index k (0..7) of the current group.
- `grp_lst_o`, output, 1: high when k == 7 (last group of the frame).

## Operation
- **Storage:** a register array of 64 complex entries per bank.
- **Write side:**
  - A write happens when `dat_val_i && dat_rdy_o`. The sample is stored at `wr_cnt` (6 bits, 0..63) in bank `wr_bank`.
  - When the write at `wr_cnt == 63` happens, the bank is marked FULL, `wr_cnt` wraps to 0, and `wr_bank` toggles (only when banking is enabled).
- **Read side:**
  - Group k presents samples k, k+8, k+16, …, k+56 in slots 0..7. Slot m holds sample k + 8*m.
  - `grp_re_o` and `grp_im_o` are a combinational mux from bank `rd_bank`, addressed by `rd_cnt` (3 bits).
  - A group transfer happens when `grp_val_o && grp_rdy_i`. On a transfer, `rd_cnt` increments.
  - When the transfer at `rd_cnt == 7` happens, the bank is marked EMPTY, `rd_cnt` wraps to 0, and `rd_bank` toggles (banked mode only).
- **Per-bank state machine:**
  - EMPTY → FILLING on the first write.
  - FILLING → FULL on the 64th write.
  - FULL → EMPTY on the last group transfer.
- **Flags:**
  - `dat_rdy_o` = bank[`wr_bank`] is not FULL. It is derived from registered state only.
  - `grp_val_o` = bank[`rd_bank`] is FULL (registered).
- **Data integrity:** no arithmetic is performed. Data passes through bit-exact, with no width change.
- **Boundary conditions:**
  - Both banks full: `dat_rdy_o` = 0. Input stalls with no data loss.
  - Bank freed in the same cycle a write is attempted to it: the write is refused, because `dat_rdy_o` is still 0. `dat_rdy_o` rises in the next cycle.
  - Simultaneous write to bank A and read from bank B: both proceed independently.
  - `grp_rdy_i` low: `grp_*_o`, `grp_idx_o` and `rd_cnt` hold stable.
  - `dat_val_i` gaps: `wr_cnt` holds. Frame assembly is gap-tolerant.
  - Reset mid-frame: the partial frame is discarded, and any unread groups are dropped.

## Timing
- **Reset values:**
  - `dat_rdy_o` = 1.
  - `grp_val_o` = 0, `grp_idx_o` = 0, `grp_lst_o` = 0.
  - `grp_re_o` and `grp_im_o` = array contents. The array is reset to 0, so they read 0.
  - Internally: `wr_cnt`, `rd_cnt`, `wr_bank` and `rd_bank` = 0; all banks EMPTY.
- **Latency:** `grp_val_o` rises in the cycle after the edge that accepts the 64th sample. Group 0 is valid then.
- **Throughput:** once full, one group per cycle while `grp_rdy_i` = 1, so 8 cycles per frame.
- **Ping-pong sustained rate:** 1 sample per cycle with no stall, provided downstream drains within 64 cycles.

## Configuration
- Macro: `FFT_BUF_IN_PINGPONG_EN`.
- **Defined:** two banks. `wr_bank` and `rd_bank` toggle as described above. Writing and reading overlap.
- **Undefined:**
  - One bank. `wr_bank` and `rd_bank` are tied to 0.
  - `dat_rdy_o` stays 0 from the 64th accepted write until the cycle after the group-7 transfer.
  - Minimum frame period: 64 + 8 + 1 cycles.

## Test plan
- **Ramp, ready held high:**
  - Stimulus: write re = n, im = −n for n = 0..63, continuous; `grp_rdy_i` = 1.
  - Response: `grp_val_o` rises 1 cycle after the 64th write.
  - Group k slots hold re = {k, k+8, …, k+56}, im negated.
  - `grp_idx_o` = 0..7; `grp_lst_o` is high only at k = 7.
- **Back-pressure:**
  - Stimulus: hold `grp_rdy_i` = 0 for 5 cycles at k = 3.
  - Response: outputs and `grp_idx_o` stay at 3; then k = 4..7 follow with no skip or duplicate.
- **Ping-pong continuity (macro defined):**
  - Stimulus: three frames back-to-back (values 0..191), with `dat_val_i` held at 1.
  - Response: `dat_rdy_o` never drops; frame 2 group 0 slot 0 = 64, frame 3 group 0 slot 0 = 128.
- **Overflow stall:**
  - Stimulus: macro defined, `grp_rdy_i` = 0, push 130 samples.
  - Response: `dat_rdy_o` falls after sample 128 is accepted; samples 129 and 130 are held upstream.
  - Releasing `grp_rdy_i` gives frame 1 (0..63) first, then frame 2.
- **Single-bank mode (macro undefined):**
  - Stimulus: two frames with `dat_val_i` held at 1.
  - Response: `dat_rdy_o` is low for exactly 9 cycles between the frames, with `grp_rdy_i` = 1.
- **Reset mid-frame:**
  - Stimulus: assert `rstn` low after 40 samples, then send a fresh 64-sample frame with values 100..163.
  - Response: first group 0 = {100, 108, …, 156}; no stale data appears.

Source files
------------

// File: rtl/fft_buf_in_if.sv
// Handshake bundle for fft_buf_in: sample stream in, stride-8 groups out.
// master drives samples and group-ready; slave is the buffer.
interface fft_buf_in_if #(
    parameter int DATA_WD = 16
);
    logic                 dat_val_i;
    logic                 dat_rdy_o;
    logic [DATA_WD-1:0]   dat_re_i;
    logic [DATA_WD-1:0]   dat_im_i;
    logic                 grp_val_o;
    logic                 grp_rdy_i;
    logic [8*DATA_WD-1:0] grp_re_o;
    logic [8*DATA_WD-1:0] grp_im_o;
    logic [2:0]           grp_idx_o;
    logic                 grp_lst_o;

    modport master (
        output dat_val_i, dat_re_i, dat_im_i, grp_rdy_i,
        input  dat_rdy_o, grp_val_o, grp_re_o, grp_im_o,
        input  grp_idx_o, grp_lst_o
    );

    modport slave (
        input  dat_val_i, dat_re_i, dat_im_i, grp_rdy_i,
        output dat_rdy_o, grp_val_o, grp_re_o, grp_im_o,
        output grp_idx_o, grp_lst_o
    );
endinterface

// File: rtl/fft_buf_in.sv
// fft_buf_in: stores a 64-sample frame, issues 8 stride-8 groups for radix-8.
// FFT_BUF_IN_PINGPONG_EN: two banks so writing and reading overlap.
module fft_buf_in #(
    parameter int DATA_WD = 16
) (
    input logic          clk,
    input logic          rstn,
    fft_buf_in_if.slave  bus
);

`ifdef FFT_BUF_IN_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bst_t;

    bst_t               bst    [NB];
    logic [DATA_WD-1:0] re_mem [NB][64];
    logic [DATA_WD-1:0] im_mem [NB][64];

    logic [5:0] wr_cnt;
    logic [2:0] rd_cnt;
    logic       wr_bank;
    logic       rd_bank;
    logic       wb_nx;
    logic       rdy_q;
    logic       rdy_nx;
    logic       wr_fire;
    logic       wr_last;
    logic       rd_fire;
    logic       rd_last;

    logic [8*DATA_WD-1:0] grp_re;
    logic [8*DATA_WD-1:0] grp_im;

    assign wr_fire = bus.dat_val_i && rdy_q;
    assign wr_last = wr_fire && (wr_cnt == 6'd63);
    assign rd_fire = bus.grp_val_o && bus.grp_rdy_i;
    assign rd_last = rd_fire && (rd_cnt == 3'd7);

`ifdef FFT_BUF_IN_PINGPONG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_last) wr_bank <= ~wr_bank;
            if (rd_last) rd_bank <= ~rd_bank;
        end
    end

    assign wb_nx = wr_bank ^ wr_last;
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
    assign wb_nx   = 1'b0;
`endif

    // A bank freed at this edge still reads FULL here, so ready
    // comes back one cycle after the freeing transfer.
    assign rdy_nx = (bst[wb_nx] != FULL) &&
                    !(wr_last && (wr_bank == wb_nx));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            rdy_q  <= 1'b1;
            for (int b = 0; b < NB; b++) begin
                bst[b] <= EMPTY;
                for (int i = 0; i < 64; i++) begin
                    re_mem[b][i] <= '0;
                    im_mem[b][i] <= '0;
                end
            end
        end else begin
            rdy_q <= rdy_nx;
            if (wr_fire) begin
                re_mem[wr_bank][wr_cnt] <= bus.dat_re_i;
                im_mem[wr_bank][wr_cnt] <= bus.dat_im_i;
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_last)
                    bst[wr_bank] <= FULL;
                else if (bst[wr_bank] == EMPTY)
                    bst[wr_bank] <= FILLING;
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 3'd1;
                if (rd_last) bst[rd_bank] <= EMPTY;
            end
        end
    end

    // Slot m of group k is sample k + 8*m, i.e. address {m, k}.
    always_comb begin
        grp_re = '0;
        grp_im = '0;
        for (int m = 0; m < 8; m++) begin
            grp_re[(7-m)*DATA_WD +: DATA_WD] =
                re_mem[rd_bank][{3'(m), rd_cnt}];
            grp_im[(7-m)*DATA_WD +: DATA_WD] =
                im_mem[rd_bank][{3'(m), rd_cnt}];
        end
    end

    assign bus.dat_rdy_o = rdy_q;
    assign bus.grp_val_o = (bst[rd_bank] == FULL);
    assign bus.grp_re_o  = grp_re;
    assign bus.grp_im_o  = grp_im;
    assign bus.grp_idx_o = rd_cnt;
    assign bus.grp_lst_o = (rd_cnt == 3'd7);

endmodule

// File: tb/tb_fft_buf_in.sv
// Directed bench for fft_buf_in: ramp, back-pressure, bank modes, reset.
// Covers the FFT_BUF_IN_PINGPONG_EN build and the default single-bank build.
module tb_fft_buf_in;

    logic clk;
    logic rstn;

    fft_buf_in_if #(.DATA_WD(16)) bus ();

    fft_buf_in #(.DATA_WD(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int nerr;
    int nchk;
    int low_cyc;

    logic [127:0] mq_re [$];
    logic [127:0] mq_im [$];
    int           mq_idx [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstn && bus.grp_val_o && bus.grp_rdy_i) begin
            mq_re.push_back(bus.grp_re_o);
            mq_im.push_back(bus.grp_im_o);
            mq_idx.push_back(int'(bus.grp_idx_o));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] exp_re(input int base,
                                            input int k);
        logic [127:0] r;
        r = '0;
        for (int m = 0; m < 8; m++)
            r[(7-m)*16 +: 16] = 16'(base + k + 8*m);
        return r;
    endfunction

    function automatic logic [127:0] exp_im(input int base,
                                            input int k);
        logic [127:0] r;
        r = '0;
        for (int m = 0; m < 8; m++)
            r[(7-m)*16 +: 16] = 16'(-(base + k + 8*m));
        return r;
    endfunction

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present sample v; hold it (valid high) until ready is seen.
    task automatic push(input int v);
        int t;
        t = 0;
        @(negedge clk);
        bus.dat_val_i = 1'b1;
        bus.dat_re_i  = 16'(v);
        bus.dat_im_i  = 16'(-v);
        while (!bus.dat_rdy_o && t < 200) begin
            low_cyc++;
            t++;
            @(negedge clk);
        end
        if (t >= 200) chk("push_timeout", 128'(bus.dat_rdy_o), 128'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.dat_val_i = 1'b0;
        end
    endtask

    task automatic mq_clear();
        mq_re.delete();
        mq_im.delete();
        mq_idx.delete();
    endtask

    initial begin
        int k;
        int hold;
        int t;
        logic exp_rdy;

        nerr = 0;
        nchk = 0;
        low_cyc = 0;
        rstn = 1'b0;
        bus.dat_val_i = 1'b0;
        bus.dat_re_i  = '0;
        bus.dat_im_i  = '0;
        bus.grp_rdy_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy", 128'(bus.dat_rdy_o), 128'd1);
        chk("rst_val", 128'(bus.grp_val_o), 128'd0);
        chk("rst_idx", 128'(bus.grp_idx_o), 128'd0);
        chk("rst_lst", 128'(bus.grp_lst_o), 128'd0);
        chk("rst_re", bus.grp_re_o, 128'd0);
        chk("rst_im", bus.grp_im_o, 128'd0);
        rstn = 1'b1;

        // Ramp with ready held high
        bus.grp_rdy_i = 1'b1;
        for (int n = 0; n < 64; n++) push(n);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.dat_val_i = 1'b0;
            if (c < 8) begin
                chk("ramp_val", 128'(bus.grp_val_o), 128'd1);
                chk("ramp_idx", 128'(bus.grp_idx_o), 128'(c));
                chk("ramp_lst", 128'(bus.grp_lst_o), 128'(c == 7));
                chk("ramp_re", bus.grp_re_o, exp_re(0, c));
                chk("ramp_im", bus.grp_im_o, exp_im(0, c));
            end else begin
                chk("ramp_drained", 128'(bus.grp_val_o), 128'd0);
            end
`ifdef FFT_BUF_IN_PINGPONG_EN
            exp_rdy = 1'b1;
`else
            exp_rdy = (c == 9);
`endif
            chk("ramp_rdy", 128'(bus.dat_rdy_o), 128'(exp_rdy));
        end
        idle(2);

        // Back-pressure: stall 5 cycles at group 3
        for (int n = 0; n < 64; n++) push(200 + n);
        @(negedge clk);
        bus.dat_val_i = 1'b0;
        k = 0;
        hold = 0;
        t = 0;
        while (k < 8 && t < 40) begin
            chk("bp_val", 128'(bus.grp_val_o), 128'd1);
            chk("bp_idx", 128'(bus.grp_idx_o), 128'(k));
            chk("bp_re", bus.grp_re_o, exp_re(200, k));
            chk("bp_im", bus.grp_im_o, exp_im(200, k));
            if (k == 3 && hold < 5) begin
                bus.grp_rdy_i = 1'b0;
                hold++;
            end else begin
                bus.grp_rdy_i = 1'b1;
                k++;
            end
            @(negedge clk);
            t++;
        end
        chk("bp_done", 128'(k), 128'd8);
        chk("bp_hold", 128'(hold), 128'd5);
        chk("bp_nodup", 128'(bus.grp_val_o), 128'd0);
        idle(3);

`ifdef FFT_BUF_IN_PINGPONG_EN
        // Three frames back-to-back, no input stall
        low_cyc = 0;
        mq_clear();
        bus.grp_rdy_i = 1'b1;
        for (int n = 0; n < 192; n++) push(n);
        idle(14);
        chk("pp_nostall", 128'(low_cyc), 128'd0);
        chk("pp_groups", 128'(mq_re.size()), 128'd24);
        chk("pp_f1g0", mq_re[0], exp_re(0, 0));
        chk("pp_f2g0", mq_re[8], exp_re(64, 0));
        chk("pp_f3g0", mq_re[16], exp_re(128, 0));
        chk("pp_f3g7", mq_im[23], exp_im(128, 7));
        chk("pp_f3idx", 128'(mq_idx[23]), 128'd7);

        // Overflow: both banks fill, input stalls without loss
        mq_clear();
        bus.grp_rdy_i = 1'b0;
        for (int n = 0; n < 128; n++) push(n);
        @(negedge clk);
        bus.dat_val_i = 1'b1;
        bus.dat_re_i  = 16'd128;
        bus.dat_im_i  = 16'(-128);
        for (int i = 0; i < 3; i++) begin
            chk("ovf_rdy", 128'(bus.dat_rdy_o), 128'd0);
            chk("ovf_val", 128'(bus.grp_val_o), 128'd1);
            chk("ovf_re", bus.grp_re_o, exp_re(0, 0));
            @(negedge clk);
        end
        bus.grp_rdy_i = 1'b1;
        push(128);
        push(129);
        idle(20);
        chk("ovf_groups", 128'(mq_re.size()), 128'd16);
        chk("ovf_f1g0", mq_re[0], exp_re(0, 0));
        chk("ovf_f1g7", mq_re[7], exp_re(0, 7));
        chk("ovf_f2g0", mq_re[8], exp_re(64, 0));
        chk("ovf_f2g5", mq_im[13], exp_im(64, 5));
`else
        // Single bank: two frames with valid held high
        low_cyc = 0;
        mq_clear();
        bus.grp_rdy_i = 1'b1;
        for (int n = 0; n < 128; n++) push(1000 + n);
        idle(14);
        chk("sb_gap", 128'(low_cyc), 128'd9);
        chk("sb_groups", 128'(mq_re.size()), 128'd16);
        chk("sb_f1g0", mq_re[0], exp_re(1000, 0));
        chk("sb_f2g0", mq_re[8], exp_re(1064, 0));
        chk("sb_f2g7", mq_im[15], exp_im(1064, 7));
        chk("sb_f2idx", 128'(mq_idx[15]), 128'd7);
`endif

        // Reset mid-frame, then a fresh frame
        bus.grp_rdy_i = 1'b1;
        for (int n = 0; n < 40; n++) push(500 + n);
        @(negedge clk);
        bus.dat_val_i = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_rdy", 128'(bus.dat_rdy_o), 128'd1);
        chk("mr_val", 128'(bus.grp_val_o), 128'd0);
        chk("mr_re", bus.grp_re_o, 128'd0);
        rstn = 1'b1;
        mq_clear();
        for (int n = 0; n < 64; n++) push(100 + n);
        idle(12);
        chk("mr_groups", 128'(mq_re.size()), 128'd8);
        chk("mr_g0_re", mq_re[0], exp_re(100, 0));
        chk("mr_g0_im", mq_im[0], exp_im(100, 0));
        chk("mr_g0_idx", 128'(mq_idx[0]), 128'd0);
        chk("mr_g7_re", mq_re[7], exp_re(100, 7));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
